hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the RV32IM five-stage core. It sits beside the ID stage and drives the stall, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers. It also computes the ID-stage forwarding enables that the ID/EX register carries into EX. It sequences load-use stalls, control-transfer flushes and multi-cycle M-extension execution.

## Interface
- MUL_LATENCY, default 2: cycles a MUL* instruction occupies EX (≥1).
- DIV_LATENCY, default 34: cycles a DIV*/REM* instruction occupies EX (≥1).
- CLK  input  1  Clock; all state updates on rising edge.
- RST  input  1  Reset, synchronous, active-high.
- ID_RS1, ID_RS2  input  5 each  Source registers of the instruction in ID.
- ID_USES_RS1, ID_USES_RS2  input  1 each  Source is actually read.
- EX_RD  input  5  Destination of the instruction in EX.
- EX_WRITE_ENABLE, EX_MEM_READ  input  1 each  EX instruction writes rd / is a load.
- MEM_RD  input  5  Destination of the instruction in MEM.
- MEM_WRITE_ENABLE  input  1  MEM instruction writes rd.
- EX_PC_SELECT  input  1  Taken branch or jump resolved in EX.
- EX_MULDIV  input  1  Instruction in EX is an M-extension op.
- EX_IS_DIV  input  1  M op is DIV/DIVU/REM/REMU; MUL* otherwise.
- ID_MEM_FORWARD_EN  output  2  Bit0 rs1, bit1 rs2: forward from MEM when the ID instruction reaches EX.
- ID_WB_FORWARD_EN  output  2  Same bit layout: forward from WB.
- PC_STALL, IF_ID_STALL, ID_EX_STALL  output  1 each  Hold the register.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  output  1 each  Load a bubble (all zeros).
- MULDIV_BUSY  output  1  M op is held in EX.
- MULDIV_DONE  output  1  One-cycle pulse in the final EX cycle of a multi-cycle op.

## Operation
- Forwarding, computed combinationally per source s:
  - A match requires ID_USES_s, a nonzero rd and the matching write enable.
  - Match against EX_RD sets the MEM bit. Match against MEM_RD sets the WB bit.
  - When both match, only the MEM bit is set.
  - A match against EX_RD with EX_MEM_READ set is a load-use hazard and sets no forwarding bit.
- Load-use: PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1 for exactly one cycle. The next cycle sees the load in MEM, which yields the WB forward bit.
- Flush: EX_PC_SELECT=1 gives IF_ID_FLUSH=ID_EX_FLUSH=1 with no stalls.
- FSM states are RUN and BUSY; a counter CNT is $clog2(DIV_LATENCY) bits wide.
  - LAT = DIV_LATENCY if EX_IS_DIV, else MUL_LATENCY.
  - RUN: EX_MULDIV=1 and LAT>1 makes MULDIV_BUSY=1 in that same cycle, loads CNT=LAT-2 and moves to BUSY. LAT=1 never stalls.
  - BUSY: MULDIV_BUSY=1. CNT==0 gives MULDIV_BUSY=0 and MULDIV_DONE=1, and the state returns to RUN. Otherwise CNT decrements.
  - While MULDIV_BUSY=1: PC_STALL=IF_ID_STALL=ID_EX_STALL=1 and EX_MEM_FLUSH=1. MEM and WB keep draining.
- Priority: flush > MULDIV stall > load-use.
  - EX_PC_SELECT cannot coincide with EX_MULDIV; if it does, flush wins and the FSM returns to RUN.
  - A load-use hazard during BUSY is masked and is re-evaluated after release.
- RST=1: the FSM goes to RUN, CNT=0 and all outputs are forced to 0 in that cycle. This applies in mid-BUSY as well; the next cycle starts clean in RUN.

## Timing
- Forwarding, load-use and flush outputs are combinational from inputs, with zero latency.
- An M op entering EX in cycle N with LAT=L:
  - MULDIV_BUSY is high in cycles N..N+L-2.
  - MULDIV_DONE pulses in cycle N+L-1.
  - The op leaves EX at the end of cycle N+L-1, so it spends exactly L cycles in EX.
- Back-to-back M ops: the second enters EX in cycle N+L and starts a fresh RUN→BUSY sequence with no idle gap.
- Reset values: state RUN, CNT 0; every output is 0 while RST is high.

## Configuration
- MULDIV_STALL_EN defined: FSM and counter are built; behaviour is as above.
- MULDIV_STALL_EN undefined: FSM and counter are removed; EX_MULDIV and EX_IS_DIV are ignored.
  - MULDIV_BUSY, MULDIV_DONE, ID_EX_STALL and EX_MEM_FLUSH are tied to 0.
  - M ops are treated as single-cycle.
  - Forwarding, load-use and flush logic is unchanged.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RUN, BUSY);
  - FWD_RS1=0 and FWD_RS2=1 bit indices;
  - default latency constants.
- Sub-module muldiv_stall_timer holds the FSM, CNT, MULDIV_BUSY and MULDIV_DONE.
  - It is instantiated only under MULDIV_STALL_EN.
  - The top level holds the forwarding compare and priority logic.

## Test plan
- EX_RD=5 with EX_WRITE_ENABLE=1 and MEM_RD=5 with MEM_WRITE_ENABLE=1; ID_RS1=5, ID_USES_RS1=1 → ID_MEM_FORWARD_EN=2'b01, ID_WB_FORWARD_EN=2'b00. EX_RD=0 → no forward.
- Load in EX (EX_MEM_READ=1, EX_RD=7) and ID_RS2=7 → one cycle of PC_STALL/IF_ID_STALL/ID_EX_FLUSH. Next cycle, with MEM_RD=7 → ID_WB_FORWARD_EN=2'b10 and no stall.
- EX_PC_SELECT=1 together with a load-use hazard → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_STALL=0.
- DIV enters EX with DIV_LATENCY=34 → MULDIV_BUSY high 33 cycles, EX_MEM_FLUSH high 33 cycles, MULDIV_DONE single pulse in cycle 34. MUL with MUL_LATENCY=2 → busy 1 cycle, done in cycle 2.
- RST asserted in the 10th BUSY cycle → all outputs 0 that cycle. After deassertion, state is RUN and no stall unless EX_MULDIV is high again.
- Build without MULDIV_STALL_EN, DIV in EX → MULDIV_BUSY=0 and no stalls; forwarding results identical to the first scenario.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the hazard controller of the five-stage
// RV32IM pipeline.
//   muldiv_state_e      : RUN / BUSY state of the M-extension stall timer
//   FWD_RS1 / FWD_RS2   : bit positions inside the 2-bit forwarding enables
//   DEFAULT_*_LATENCY   : default EX occupancy of MUL* and DIV*/REM* ops
//   rd_match()          : one source-vs-destination forwarding compare
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        BUSY = 1'b1
    } muldiv_state_e;

    localparam int FWD_RS1 = 0;
    localparam int FWD_RS2 = 1;

    localparam int DEFAULT_MUL_LATENCY = 2;
    localparam int DEFAULT_DIV_LATENCY = 34;

    // A source hits a later-stage destination only when it is really read,
    // the destination is written and it is not x0.
    function automatic logic rd_match(input logic       uses,
                                      input logic [4:0] rs,
                                      input logic [4:0] rd,
                                      input logic       we);
        return uses && we && (rs != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of pipeline-status inputs and stall/flush/forward controls of the
// hazard controller.
//   slave  : the hazard controller (reads pipeline status, drives controls)
//   master : the pipeline / testbench side (drives status, reads controls)
// Inputs : ID_RS1/2, ID_USES_RS1/2, EX_RD, EX_WRITE_ENABLE, EX_MEM_READ,
//          MEM_RD, MEM_WRITE_ENABLE, EX_PC_SELECT, EX_MULDIV, EX_IS_DIV
// Outputs: ID_MEM_FORWARD_EN, ID_WB_FORWARD_EN, PC_STALL, IF_ID_STALL,
//          ID_EX_STALL, IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH,
//          MULDIV_BUSY, MULDIV_DONE
// All controls are level signals sampled by the pipeline registers on the
// next rising clock edge; there is no valid/ready handshake on this bundle.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic [4:0] ID_RS1;
    logic [4:0] ID_RS2;
    logic       ID_USES_RS1;
    logic       ID_USES_RS2;
    logic [4:0] EX_RD;
    logic       EX_WRITE_ENABLE;
    logic       EX_MEM_READ;
    logic [4:0] MEM_RD;
    logic       MEM_WRITE_ENABLE;
    logic       EX_PC_SELECT;
    logic       EX_MULDIV;
    logic       EX_IS_DIV;

    logic [1:0] ID_MEM_FORWARD_EN;
    logic [1:0] ID_WB_FORWARD_EN;
    logic       PC_STALL;
    logic       IF_ID_STALL;
    logic       ID_EX_STALL;
    logic       IF_ID_FLUSH;
    logic       ID_EX_FLUSH;
    logic       EX_MEM_FLUSH;
    logic       MULDIV_BUSY;
    logic       MULDIV_DONE;

    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
               EX_RD, EX_WRITE_ENABLE, EX_MEM_READ,
               MEM_RD, MEM_WRITE_ENABLE,
               EX_PC_SELECT, EX_MULDIV, EX_IS_DIV,
        output ID_MEM_FORWARD_EN, ID_WB_FORWARD_EN,
               PC_STALL, IF_ID_STALL, ID_EX_STALL,
               IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH,
               MULDIV_BUSY, MULDIV_DONE
    );

    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
               EX_RD, EX_WRITE_ENABLE, EX_MEM_READ,
               MEM_RD, MEM_WRITE_ENABLE,
               EX_PC_SELECT, EX_MULDIV, EX_IS_DIV,
        input  ID_MEM_FORWARD_EN, ID_WB_FORWARD_EN,
               PC_STALL, IF_ID_STALL, ID_EX_STALL,
               IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH,
               MULDIV_BUSY, MULDIV_DONE
    );

endinterface

// File: rtl/hazard_ctrl_muldiv_stall_timer.sv
// ---------------------------------------------------------------------------
// muldiv_stall_timer
// Counts the EX occupancy of a multi-cycle M-extension op.
//   CLK, RST   : clock, synchronous active-high reset
//   ex_muldiv  : M op present in EX
//   ex_is_div  : M op is DIV*/REM* (else MUL*)
//   abort      : taken branch/jump in EX; cancels any sequence
//   busy       : hold the op in EX this cycle
//   done       : final EX cycle of a multi-cycle op (one-cycle pulse)
//   state_dbg  : current FSM state
// An op of latency L raises busy in its first L-1 cycles and done in cycle L.
// The first busy cycle is produced combinationally in RUN, so the counter is
// loaded with L-2 and BUSY ends when it reaches zero.
// ---------------------------------------------------------------------------
module muldiv_stall_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ex_muldiv,
    input  logic          ex_is_div,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output muldiv_state_e state_dbg
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0);
    localparam logic             MUL_MULTI = (MUL_LATENCY > 1);
    localparam logic             DIV_MULTI = (DIV_LATENCY > 1);

    muldiv_state_e    state;
    muldiv_state_e    state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             start;

    // Single-cycle ops never start a sequence; a flush suppresses the start.
    assign start     = ex_muldiv && (ex_is_div ? DIV_MULTI : MUL_MULTI) && !abort;
    assign cnt_load  = ex_is_div ? DIV_LOAD : MUL_LOAD;
    assign state_dbg = state;

    // State register and counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == RUN && start) begin
                cnt <= cnt_load;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (start) state_nxt = BUSY;
            BUSY: if (abort || cnt == '0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (!RST) begin
            unique case (state)
                RUN:  busy = start;
                BUSY: begin
                    if (!abort) begin
                        if (cnt == '0) done = 1'b1;
                        else           busy = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the five-stage RV32IM pipeline: ID-stage forwarding
// enables, load-use stall, control-transfer flush and M-extension stall.
//   CLK, RST  : clock, synchronous active-high reset (all outputs 0 while high)
//   hz        : hazard_ctrl_if.slave bundle (pipeline status in, controls out)
//   dbg_state : state of the M-extension stall timer (RUN when not built)
// Build option: MULDIV_STALL_EN. When defined, the muldiv_stall_timer is
// built and M ops hold EX for their latency. When undefined, M ops are
// single-cycle and EX_MULDIV / EX_IS_DIV are ignored.
// Priority: flush > M-op stall > load-use.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  hz,
    output muldiv_state_e dbg_state
);

    logic [1:0] ex_hit;
    logic [1:0] mem_hit;
    logic [1:0] mem_fwd;
    logic [1:0] wb_fwd;
    logic       load_use;
    logic       flush;
    logic       md_busy;
    logic       md_done;

`ifdef MULDIV_STALL_EN
    muldiv_stall_timer #(
        .MUL_LATENCY (MUL_LATENCY),
        .DIV_LATENCY (DIV_LATENCY)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .ex_muldiv (hz.EX_MULDIV),
        .ex_is_div (hz.EX_IS_DIV),
        .abort     (hz.EX_PC_SELECT),
        .busy      (md_busy),
        .done      (md_done),
        .state_dbg (dbg_state)
    );
`else
    logic unused_md;
    assign unused_md = ^{CLK, hz.EX_MULDIV, hz.EX_IS_DIV,
                         32'(MUL_LATENCY), 32'(DIV_LATENCY)};
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign dbg_state = RUN;
`endif

    // Forwarding compare. The EX match is the younger producer and wins over
    // MEM; a load in EX has no data yet, so it is a load-use stall instead.
    always_comb begin
        ex_hit[FWD_RS1]  = rd_match(hz.ID_USES_RS1, hz.ID_RS1, hz.EX_RD, hz.EX_WRITE_ENABLE);
        ex_hit[FWD_RS2]  = rd_match(hz.ID_USES_RS2, hz.ID_RS2, hz.EX_RD, hz.EX_WRITE_ENABLE);
        mem_hit[FWD_RS1] = rd_match(hz.ID_USES_RS1, hz.ID_RS1, hz.MEM_RD, hz.MEM_WRITE_ENABLE);
        mem_hit[FWD_RS2] = rd_match(hz.ID_USES_RS2, hz.ID_RS2, hz.MEM_RD, hz.MEM_WRITE_ENABLE);
        mem_fwd          = ex_hit & ~{2{hz.EX_MEM_READ}};
        wb_fwd           = mem_hit & ~ex_hit;
        load_use         = |(ex_hit & {2{hz.EX_MEM_READ}});
        flush            = hz.EX_PC_SELECT;
    end

    // Priority and reset gating of every control output.
    always_comb begin
        hz.ID_MEM_FORWARD_EN = '0;
        hz.ID_WB_FORWARD_EN  = '0;
        hz.PC_STALL          = 1'b0;
        hz.IF_ID_STALL       = 1'b0;
        hz.ID_EX_STALL       = 1'b0;
        hz.IF_ID_FLUSH       = 1'b0;
        hz.ID_EX_FLUSH       = 1'b0;
        hz.EX_MEM_FLUSH      = 1'b0;
        hz.MULDIV_BUSY       = 1'b0;
        hz.MULDIV_DONE       = 1'b0;
        if (!RST) begin
            hz.ID_MEM_FORWARD_EN = mem_fwd;
            hz.ID_WB_FORWARD_EN  = wb_fwd;
            if (flush) begin
                hz.IF_ID_FLUSH = 1'b1;
                hz.ID_EX_FLUSH = 1'b1;
            end else if (md_busy) begin
                // Freeze PC..ID/EX; the bubble into EX/MEM lets MEM/WB drain.
                hz.PC_STALL     = 1'b1;
                hz.IF_ID_STALL  = 1'b1;
                hz.ID_EX_STALL  = 1'b1;
                hz.EX_MEM_FLUSH = 1'b1;
                hz.MULDIV_BUSY  = 1'b1;
            end else if (load_use) begin
                hz.PC_STALL    = 1'b1;
                hz.IF_ID_STALL = 1'b1;
                hz.ID_EX_FLUSH = 1'b1;
            end
            hz.MULDIV_DONE = md_done && !flush;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed vectors for hazard_ctrl (MUL_LATENCY=2, DIV_LATENCY=34). Each
// driven cycle pushes a hand-computed output vector into exp_q; a monitor on
// the falling edge pops and compares against the DUT outputs.
// Expected vector layout [11:0]:
//   {MEM_FWD[1:0], WB_FWD[1:0], PC_STALL, IF_ID_STALL, ID_EX_STALL,
//    IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_BUSY, MULDIV_DONE}
// With MULDIV_STALL_EN undefined the M-op cycles expect no stall.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int W = 12;

`ifdef MULDIV_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [W-1:0] E_NONE  = 12'b0000_0000_0000;
    localparam logic [W-1:0] E_BUSY  = 12'b0000_1110_0110;
    localparam logic [W-1:0] E_DONE  = 12'b0000_0000_0001;
    localparam logic [W-1:0] E_LU    = 12'b0000_1100_1000;
    localparam logic [W-1:0] E_FLUSH = 12'b0000_0001_1000;
    localparam logic [W-1:0] E_BUSY_X = MD_EN ? E_BUSY : E_NONE;
    localparam logic [W-1:0] E_DONE_X = MD_EN ? E_DONE : E_NONE;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RST;
    muldiv_state_e dbg_state;

    always #5 CLK = ~CLK;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MUL_LATENCY (2),
        .DIV_LATENCY (34)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .hz        (hif),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] dut_vec();
        return {hif.ID_MEM_FORWARD_EN, hif.ID_WB_FORWARD_EN,
                hif.PC_STALL, hif.IF_ID_STALL, hif.ID_EX_STALL,
                hif.IF_ID_FLUSH, hif.ID_EX_FLUSH, hif.EX_MEM_FLUSH,
                hif.MULDIV_BUSY, hif.MULDIV_DONE};
    endfunction

    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = dut_vec();
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got %b expected %b (t=%0t)", nm, a, e, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        hif.ID_RS1           = 5'd0;
        hif.ID_RS2           = 5'd0;
        hif.ID_USES_RS1      = 1'b0;
        hif.ID_USES_RS2      = 1'b0;
        hif.EX_RD            = 5'd0;
        hif.EX_WRITE_ENABLE  = 1'b0;
        hif.EX_MEM_READ      = 1'b0;
        hif.MEM_RD           = 5'd0;
        hif.MEM_WRITE_ENABLE = 1'b0;
        hif.EX_PC_SELECT     = 1'b0;
        hif.EX_MULDIV        = 1'b0;
        hif.EX_IS_DIV        = 1'b0;
    endtask

    // Inputs are already set; queue the expectation and advance one cycle.
    task automatic step(input logic [W-1:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load_use_rs2();
        hif.EX_MEM_READ     = 1'b1;
        hif.EX_RD           = 5'd7;
        hif.EX_WRITE_ENABLE = 1'b1;
        hif.ID_RS2          = 5'd7;
        hif.ID_USES_RS2     = 1'b1;
    endtask

    task automatic mul_op(input string tag);
        hif.EX_MULDIV = 1'b1;
        hif.EX_IS_DIV = 1'b0;
        step(E_BUSY_X, {tag, "_busy"});
        step(E_DONE_X, {tag, "_done"});
        hif.EX_MULDIV = 1'b0;
        step(E_NONE, {tag, "_idle"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Reset: a forwarding match must still read as all zeros.
        hif.EX_RD = 5'd5;  hif.EX_WRITE_ENABLE = 1'b1;
        hif.MEM_RD = 5'd5; hif.MEM_WRITE_ENABLE = 1'b1;
        hif.ID_RS1 = 5'd5; hif.ID_USES_RS1 = 1'b1;
        step(E_NONE, "reset_outputs");
        RST = 1'b0;

        // Forwarding
        step({2'b01, 2'b00, 8'h00}, "fwd_both_match_mem_wins");
        hif.EX_RD = 5'd0;
        step({2'b00, 2'b01, 8'h00}, "fwd_ex_rd0_wb_only");
        hif.MEM_RD = 5'd0;
        step(E_NONE, "fwd_rd0_none");
        hif.EX_RD = 5'd5; hif.EX_WRITE_ENABLE = 1'b0; hif.MEM_RD = 5'd5;
        step({2'b00, 2'b01, 8'h00}, "fwd_ex_we0_wb");
        clear_inputs();
        hif.ID_RS1 = 5'd12; hif.ID_USES_RS1 = 1'b1;
        hif.EX_RD = 5'd12;  hif.EX_WRITE_ENABLE = 1'b1;
        hif.ID_RS2 = 5'd9;  hif.ID_USES_RS2 = 1'b1;
        hif.MEM_RD = 5'd9;  hif.MEM_WRITE_ENABLE = 1'b1;
        step({2'b01, 2'b10, 8'h00}, "fwd_rs1_mem_rs2_wb");
        hif.ID_USES_RS1 = 1'b0; hif.ID_USES_RS2 = 1'b0;
        step(E_NONE, "fwd_uses_off");

        // Load-use, then the load reaches MEM and forwards from WB
        clear_inputs();
        set_load_use_rs2();
        step(E_LU, "load_use_rs2");
        hif.EX_MEM_READ = 1'b0; hif.EX_RD = 5'd0; hif.EX_WRITE_ENABLE = 1'b0;
        hif.MEM_RD = 5'd7; hif.MEM_WRITE_ENABLE = 1'b1;
        step({2'b00, 2'b10, 8'h00}, "load_use_release_wb");

        // Flush beats load-use
        clear_inputs();
        set_load_use_rs2();
        hif.EX_PC_SELECT = 1'b1;
        step(E_FLUSH, "flush_over_load_use");
        clear_inputs();
        hif.EX_PC_SELECT = 1'b1;
        step(E_FLUSH, "flush_alone");
        clear_inputs();

        // MUL back to back: second op enters right after the first's DONE
        hif.EX_MULDIV = 1'b1;
        hif.EX_IS_DIV = 1'b0;
        step(E_BUSY_X, "mul1_busy");
        step(E_DONE_X, "mul1_done");
        step(E_BUSY_X, "mul2_busy");
        step(E_DONE_X, "mul2_done");
        hif.EX_MULDIV = 1'b0;
        step(E_NONE, "mul_idle");

        // DIV: 33 busy cycles, load-use in cycle 5 is masked, DONE in cycle 34
        hif.EX_MULDIV = 1'b1;
        hif.EX_IS_DIV = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            if (i == 5) begin
                set_load_use_rs2();
                step(MD_EN ? E_BUSY : E_LU, "div_busy_load_use_masked");
                hif.EX_MEM_READ = 1'b0; hif.EX_RD = 5'd0;
                hif.EX_WRITE_ENABLE = 1'b0; hif.ID_USES_RS2 = 1'b0;
            end else begin
                step(E_BUSY_X, "div_busy");
            end
        end
        step(E_DONE_X, "div_done");
        hif.EX_MULDIV = 1'b0;
        hif.EX_IS_DIV = 1'b0;
        step(E_NONE, "div_idle");

        // Reset in the 10th busy cycle of a DIV
        hif.EX_MULDIV = 1'b1;
        hif.EX_IS_DIV = 1'b1;
        for (int i = 1; i <= 9; i++) step(E_BUSY_X, "rst_div_busy");
        RST = 1'b1;
        step(E_NONE, "rst_in_busy");
        RST = 1'b0;
        hif.EX_MULDIV = 1'b0;
        hif.EX_IS_DIV = 1'b0;
        step(E_NONE, "after_rst_no_stall");
        step(E_NONE, "after_rst_no_stall2");
        mul_op("after_rst_mul");

        // Flush during BUSY returns the FSM to RUN
        hif.EX_MULDIV = 1'b1;
        hif.EX_IS_DIV = 1'b1;
        for (int i = 1; i <= 3; i++) step(E_BUSY_X, "flush_div_busy");
        hif.EX_PC_SELECT = 1'b1;
        step(E_FLUSH, "flush_in_busy");
        hif.EX_PC_SELECT = 1'b0;
        hif.EX_MULDIV = 1'b0;
        hif.EX_IS_DIV = 1'b0;
        step(E_NONE, "after_flush_run");
        mul_op("after_flush_mul");

        // Flush coinciding with an M op in RUN: no sequence starts
        hif.EX_MULDIV = 1'b1;
        hif.EX_PC_SELECT = 1'b1;
        step(E_FLUSH, "flush_with_mul_in_run");
        clear_inputs();
        step(E_NONE, "after_flush_mul_no_done");

        // Drain: every queued expectation must have been checked
        @(negedge CLK);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
